// File: rtl/exe_stage.sv
// exe_stage: LoongArch execute stage with single-cycle ALU, iterative radix-2 divider and data_sram request.
`ifndef DS_TO_ES_BUS_WD
`define DS_TO_ES_BUS_WD 152
`endif
`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 71
`endif

module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    logic        sub;
    logic [32:0] sum;
    logic        slt;
    logic        sltu;
    assign sub  = alu_op[1] | alu_op[2] | alu_op[3];
    assign sum  = {1'b0, alu_src1} + {1'b0, (sub ? ~alu_src2 : alu_src2)} + {32'd0, sub};
    assign sltu = ~sum[32];
    assign slt  = (alu_src1[31] & ~alu_src2[31]) | (~(alu_src1[31] ^ alu_src2[31]) & sum[31]);
    assign alu_result = ({32{alu_op[0] | alu_op[1]}} & sum[31:0])
                      | ({32{alu_op[2]}}  & {31'd0, slt})
                      | ({32{alu_op[3]}}  & {31'd0, sltu})
                      | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                      | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                      | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                      | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                      | ({32{alu_op[8]}}  & (alu_src1 << alu_src2[4:0]))
                      | ({32{alu_op[9]}}  & (alu_src1 >> alu_src2[4:0]))
                      | ({32{alu_op[10]}} & ($signed(alu_src1) >>> alu_src2[4:0]))
                      | ({32{alu_op[11]}} & alu_src2);
endmodule

module exe_stage (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        ms_allowin,
    output logic                        es_allowin,
    input  logic                        ds_to_es_valid,
    input  logic [`DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                        es_to_ms_valid,
    output logic [`ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                        data_sram_en,
    output logic [3:0]                  data_sram_we,
    output logic [31:0]                 data_sram_addr,
    output logic [31:0]                 data_sram_wdata
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    logic                        es_valid;
    logic                        es_ready_go;
    logic [`DS_TO_ES_BUS_WD-1:0] es_bus;
    logic [11:0]                 alu_op;
    logic [3:0]                  div_op;
    logic [31:0]                 src1;
    logic [31:0]                 src2;
    logic [31:0]                 rkd_value;
    logic                        res_from_mem;
    logic                        mem_we;
    logic                        gr_we;
    logic [4:0]                  dest;
    logic [31:0]                 pc;
    logic [31:0]                 alu_result;
    logic [31:0]                 es_result;

    div_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic [32:0] shl;
    logic [32:0] diff;
    logic        is_div;
    logic        sgn;
    logic        div_zero;
    logic [31:0] q_res;
    logic [31:0] r_res;

    assign {alu_op, div_op, src1, src2, rkd_value, res_from_mem, mem_we, gr_we, dest, pc} = es_bus;

    assign is_div      = |div_op;
    assign sgn         = div_op[3] | div_op[2];
    assign es_ready_go = !is_div || state == DONE;
    assign es_allowin  = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            es_valid <= 1'b0;
        else if (es_allowin)
            es_valid <= ds_to_es_valid;
    end

    always_ff @(posedge clk) begin
        if (es_allowin && ds_to_es_valid)
            es_bus <= ds_to_es_bus;
    end

    alu u_alu (
        .alu_op    (alu_op),
        .alu_src1  (src1),
        .alu_src2  (src2),
        .alu_result(alu_result)
    );

    // Restoring step: dividend bits shift out of quo's MSB into the partial remainder.
    assign shl  = {rem, quo[31]};
    assign diff = shl - {1'b0, dvs};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 5'd0;
            quo   <= 32'd0;
            rem   <= 32'd0;
            dvs   <= 32'd0;
        end else begin
            case (state)
                IDLE: if (es_valid && is_div) begin
                    state <= RUN;
                    cnt   <= 5'd0;
                    quo   <= (sgn && src1[31]) ? 32'd0 - src1 : src1;
                    dvs   <= (sgn && src2[31]) ? 32'd0 - src2 : src2;
                    rem   <= 32'd0;
                end
                RUN: begin
                    cnt   <= cnt + 5'd1;
                    quo   <= {quo[30:0], ~diff[32]};
                    rem   <= diff[32] ? shl[31:0] : diff[31:0];
                    state <= cnt == 5'd31 ? DONE : RUN;
                end
                DONE: if (ms_allowin) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Divide by zero bypasses sign correction: all-ones quotient, raw dividend remainder.
    assign div_zero  = src2 == 32'd0;
    assign q_res     = div_zero ? 32'hFFFF_FFFF : (sgn && (src1[31] ^ src2[31])) ? 32'd0 - quo : quo;
    assign r_res     = div_zero ? src1 : (sgn && src1[31]) ? 32'd0 - rem : rem;
    assign es_result = is_div ? ((div_op[3] | div_op[1]) ? q_res : r_res) : alu_result;

    assign es_to_ms_bus    = {res_from_mem, gr_we, dest, es_result, pc};
    assign data_sram_en    = es_valid && (res_from_mem || mem_we) && ms_allowin;
    assign data_sram_we    = {4{es_valid && mem_we && ms_allowin}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vectors for exe_stage covering ALU pass-through, divider timing/results, backpressure, stores and reset.
module tb_exe_stage;
    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         ms_allowin = 1'b1;
    logic         es_allowin;
    logic         ds_to_es_valid = 1'b0;
    logic [151:0] ds_to_es_bus = '0;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .ms_allowin     (ms_allowin),
        .es_allowin     (es_allowin),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .data_sram_en   (data_sram_en),
        .data_sram_we   (data_sram_we),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [151:0] mk(input logic [11:0] aop, input logic [3:0] dop,
                                        input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rkd,
                                        input logic rfm, input logic mwe, input logic gwe,
                                        input logic [4:0] dest, input logic [31:0] pc);
        return {aop, dop, s1, s2, rkd, rfm, mwe, gwe, dest, pc};
    endfunction

    task automatic issue(input logic [151:0] b);
        @(posedge clk);
        #1;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = b;
        @(posedge clk);
        #1;
        ds_to_es_valid = 1'b0;
    endtask

    task automatic run_div(input string tag, input logic [3:0] dop, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] exp);
        int   k = 0;
        logic blocked = 1'b1;
        issue(mk(12'd0, dop, s1, s2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1C00_0100));
        @(negedge clk);
        while (!es_to_ms_valid && k < 60) begin
            blocked &= !es_allowin;
            k++;
            @(negedge clk);
        end
        check({tag, " latency"}, k, 33);
        check({tag, " blocked"}, {31'd0, blocked}, 32'd1);
        check({tag, " result"}, es_to_ms_bus[63:32], exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst es_to_ms_valid", {31'd0, es_to_ms_valid}, 32'd0);
        check("rst es_allowin", {31'd0, es_allowin}, 32'd1);
        check("rst sram_en", {31'd0, data_sram_en}, 32'd0);
        check("rst sram_we", {28'd0, data_sram_we}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        issue(mk(12'h001, 4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1C00_0010));
        @(negedge clk);
        check("add valid", {31'd0, es_to_ms_valid}, 32'd1);
        check("add result", es_to_ms_bus[63:32], 32'd12);
        check("add dest", {27'd0, es_to_ms_bus[68:64]}, 32'd3);
        check("add pc", es_to_ms_bus[31:0], 32'h1C00_0010);
        check("add gr_we", {31'd0, es_to_ms_bus[69]}, 32'd1);

        run_div("div.w", 4'b1000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div("mod.w", 4'b0100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div("mod.wu", 4'b0001, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F);
        run_div("div.wu", 4'b0010, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);
        run_div("div.w zero", 4'b1000, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_div("mod.w zero", 4'b0100, 32'h1234_5678, 32'd0, 32'h1234_5678);
        run_div("div.w ovf", 4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("mod.w ovf", 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        issue(mk(12'd0, 4'b0010, 32'hFFFF_FFFF, 32'h10, 32'd0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h1C00_0180));
        repeat (30) @(posedge clk);
        #1 ms_allowin = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp valid", {31'd0, es_to_ms_valid}, 32'd1);
        check("bp result", es_to_ms_bus[63:32], 32'h0FFF_FFFF);
        check("bp allowin", {31'd0, es_allowin}, 32'd0);
        @(posedge clk);
        #1;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(12'h001, 4'd0, 32'd100, 32'd23, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h1C00_0200);
        @(negedge clk);
        check("bp release allowin", {31'd0, es_allowin}, 32'd1);
        @(posedge clk);
        #1 ds_to_es_valid = 1'b0;
        @(negedge clk);
        check("bp next valid", {31'd0, es_to_ms_valid}, 32'd1);
        check("bp next result", es_to_ms_bus[63:32], 32'd123);
        check("bp next pc", es_to_ms_bus[31:0], 32'h1C00_0200);

        issue(mk(12'h001, 4'd0, 32'h1C00_7FF0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1C00_0300));
        @(negedge clk);
        check("st en", {31'd0, data_sram_en}, 32'd1);
        check("st we", {28'd0, data_sram_we}, 32'hF);
        check("st addr", data_sram_addr, 32'h1C00_8000);
        check("st wdata", data_sram_wdata, 32'hDEAD_BEEF);
        issue(mk(12'h001, 4'd0, 32'h1C00_7FF0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1C00_0304));
        ms_allowin = 1'b0;
        @(negedge clk);
        check("st stall en", {31'd0, data_sram_en}, 32'd0);
        check("st stall we", {28'd0, data_sram_we}, 32'd0);
        ms_allowin = 1'b1;

        issue(mk(12'd0, 4'b1000, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1C00_0400));
        repeat (10) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midrst valid", {31'd0, es_to_ms_valid}, 32'd0);
        check("midrst allowin", {31'd0, es_allowin}, 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        issue(mk(12'h001, 4'd0, 32'd40, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1C00_0500));
        @(negedge clk);
        check("postrst valid", {31'd0, es_to_ms_valid}, 32'd1);
        check("postrst result", es_to_ms_bus[63:32], 32'd42);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("postrst empty", {31'd0, es_to_ms_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
